// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and helpers for the MIPS data memory responder
package mips_mem_pkg;

    typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE} mem_state_t;

    localparam int WORD_BYTES = 4;

    typedef logic [7:0] byte_lane_t;

    // An access faults when it is not word aligned or touches bytes beyond the decoded range
    function automatic logic addr_fault(input logic [31:0] addr, input int addr_width);
        logic f;
        f = (addr[1:0] != 2'b00);
        for (int i = 2; i < 32; i++) begin
            if (i >= addr_width && addr[i]) begin
                f = 1'b1;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/mips_data_mem_if.sv
// rtl/mips_data_mem_if.sv - core-side data port bundle between the MIPS core and its memory
interface mips_data_mem_if;
    import mips_mem_pkg::*;

    logic       req;
    logic [31:0] mem_addr;
    logic       mem_write_en;
    byte_lane_t mem_data_in [0:WORD_BYTES-1];
    logic       halted;
    byte_lane_t mem_data_out [0:WORD_BYTES-1];
    logic       mem_ready;
    logic       mem_err;
    logic       busy;

    modport master (
        output req, mem_addr, mem_write_en, mem_data_in, halted,
        input  mem_data_out, mem_ready, mem_err, busy
    );

    modport slave (
        input  req, mem_addr, mem_write_en, mem_data_in, halted,
        output mem_data_out, mem_ready, mem_err, busy
    );

endinterface

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - one byte lane of data memory with synchronous write and registered read
module mem_bank
    import mips_mem_pkg::*;
#(
    parameter int IDX_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 we,
    input  logic                 re,
    input  logic                 clr,
    input  logic [IDX_WIDTH-1:0] idx,
    input  byte_lane_t           wdata,
    output byte_lane_t           rdata
);

    byte_lane_t mem [0:(1 << IDX_WIDTH)-1];

    // Array storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register holds its value between accesses; a faulted access zeroes it
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mips_data_mem.sv
// rtl/mips_data_mem.sv - fixed-latency word memory responder for the MIPS data port
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    mips_data_mem_if.slave    bus
);

    localparam int IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    mem_state_t       state;
    mem_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic             we_q;
    byte_lane_t       data_q [0:WORD_BYTES-1];
    logic             err_q;

    logic             accept;
    logic             commit;
    logic [31:0]      acc_addr;
    logic             acc_we;
    byte_lane_t       acc_data [0:WORD_BYTES-1];
    logic             fault;
    logic             bank_we;
    logic             bank_re;
    logic             bank_clr;
    byte_lane_t       rdata [0:WORD_BYTES-1];

    assign accept = (state == MEM_IDLE) && bus.req && !bus.halted;

    // With single-cycle latency the access commits on the accepting edge, so use the live bus
    assign acc_addr = (state == MEM_IDLE) ? bus.mem_addr : addr_q;
    assign acc_we   = (state == MEM_IDLE) ? bus.mem_write_en : we_q;
    assign acc_data = (state == MEM_IDLE) ? bus.mem_data_in : data_q;

    assign fault = addr_fault(acc_addr, ADDR_WIDTH);

    // Reset on the commit edge must abort the access, so it gates the array write too
    assign commit   = rst_b && (next_state == MEM_DONE) && (state != MEM_DONE);
    assign bank_we  = commit && acc_we && !fault;
    assign bank_re  = commit && !acc_we && !fault;
    assign bank_clr = commit && fault;

    // Next-state selection for the request/latency/complete sequence
    always_comb begin
        next_state = state;
        case (state)
            MEM_IDLE: if (accept) next_state = (LATENCY > 1) ? MEM_BUSY : MEM_DONE;
            MEM_BUSY: if (cnt == '0) next_state = MEM_DONE;
            MEM_DONE: next_state = MEM_IDLE;
            default:  next_state = MEM_IDLE;
        endcase
    end

    // State, latency counter and completion error flag
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= MEM_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= commit && fault;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == MEM_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Request latch: the core may change the bus while the access is in flight
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= bus.mem_addr;
            we_q   <= bus.mem_write_en;
            data_q <= bus.mem_data_in;
        end
    end

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
        mem_bank #(.IDX_WIDTH(IDX_WIDTH)) u_bank (
            .clk   (clk),
            .rst_b (rst_b),
            .we    (bank_we),
            .re    (bank_re),
            .clr   (bank_clr),
            .idx   (acc_addr[ADDR_WIDTH-1:2]),
            .wdata (acc_data[g]),
            .rdata (rdata[g])
        );
    end

    assign bus.mem_data_out = rdata;
    assign bus.mem_ready    = (state == MEM_DONE);
    assign bus.busy         = (state != MEM_IDLE);
    assign bus.mem_err      = err_q;

endmodule

// File: tb/tb_mips_data_mem.sv
// tb/tb_mips_data_mem.sv - self-checking bench for mips_data_mem
module tb_mips_data_mem;
    import mips_mem_pkg::*;

    localparam int ADDR_WIDTH = 12;
    localparam int LATENCY    = 2;
    localparam int WORDS      = 1 << (ADDR_WIDTH - 2);

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    mips_data_mem_if bus();

    mips_data_mem #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [0:WORDS-1];
    bit          known     [0:WORDS-1];
    logic [31:0] model_out;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        halt_mid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [0:11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] out_word();
        return {bus.mem_data_out[0], bus.mem_data_out[1], bus.mem_data_out[2], bus.mem_data_out[3]};
    endfunction

    task automatic set_lanes(input logic [31:0] w);
        bus.mem_data_in[0] = w[31:24];
        bus.mem_data_in[1] = w[23:16];
        bus.mem_data_in[2] = w[15:8];
        bus.mem_data_in[3] = w[7:0];
    endtask

    task automatic model_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                output logic [31:0] exp_d, output logic exp_e);
        int idx;
        bit flt;
        flt = (addr % 4 != 0) || (addr >= (32'd1 << ADDR_WIDTH));
        idx = int'(addr / 4) % WORDS;
        exp_e = flt;
        if (flt) begin
            model_out = 32'h0;
        end else if (we) begin
            model_mem[idx] = wdata;
            known[idx] = 1'b1;
        end else begin
            model_out = model_mem[idx];
        end
        exp_d = model_out;
    endtask

    task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic halt_mid, input logic [31:0] exp_d, input logic exp_e,
                             input string tag);
        int k;
        @(negedge clk);
        bus.req = 1'b1;
        bus.mem_addr = addr;
        bus.mem_write_en = we;
        set_lanes(wdata);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        bus.mem_addr = $urandom;
        set_lanes($urandom);
        if (halt_mid) bus.halted = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.mem_ready && k < 20);
        check({tag, " latency"}, k, LATENCY);
        check({tag, " data"}, out_word(), exp_d);
        check({tag, " err"}, {31'h0, bus.mem_err}, {31'h0, exp_e});
        bus.halted = 1'b0;
        @(negedge clk);
        check({tag, " pulse_end"}, {30'h0, bus.mem_ready, bus.busy}, 32'h0);
    endtask

    initial begin
        logic [31:0] ed;
        logic        ee;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        int          idx;
        int          sel;

        bus.req = 1'b0;
        bus.mem_addr = '0;
        bus.mem_write_en = 1'b0;
        bus.halted = 1'b0;
        set_lanes(32'h0);
        model_out = 32'h0;
        for (int i = 0; i < WORDS; i++) known[i] = 1'b0;

        // Reset held for two cycles
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", {31'h0, bus.mem_ready}, 32'h0);
        check("reset err", {31'h0, bus.mem_err}, 32'h0);
        check("reset busy", {31'h0, bus.busy}, 32'h0);
        check("reset lanes", out_word(), 32'h0);
        rst_b = 1'b1;

        // Directed vectors
        vecs = '{
            '{32'h0000_0010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h0000_0010, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0},
            '{32'h0000_0012, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b1},
            '{32'h0001_0000, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b1},
            '{32'h0000_0010, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0},
            '{32'h0000_0014, 1'b1, 32'h01020304, 1'b0, 32'hDEADBEEF, 1'b0},
            '{32'h0000_0013, 1'b1, 32'h55555555, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h0000_0014, 1'b0, 32'h0,        1'b1, 32'h01020304, 1'b0},
            '{32'h0000_0FFC, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h01020304, 1'b0},
            '{32'h0000_0FFC, 1'b0, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0},
            '{32'h0000_1000, 1'b1, 32'h77777777, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h0000_0010, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0}
        };
        for (int i = 0; i < 12; i++) begin
            model_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, ed, ee);
            do_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].halt_mid,
                      vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Continuous request: one completion every LATENCY+1 cycles
        @(negedge clk);
        bus.req = 1'b1;
        bus.mem_addr = 32'h10;
        bus.mem_write_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("stream ready k%0d", k), {31'h0, bus.mem_ready}, {31'h0, (k % 3) == 2});
            check($sformatf("stream busy k%0d", k), {31'h0, bus.busy}, {31'h0, (k % 3) != 0});
            if ((k % 3) == 2) check($sformatf("stream data k%0d", k), out_word(), 32'hDEADBEEF);
        end
        bus.req = 1'b0;
        model_out = 32'hDEADBEEF;

        // Reset right after accepting a write aborts it
        model_access(32'h20, 1'b1, 32'hCAFEF00D, ed, ee);
        do_access(32'h20, 1'b1, 32'hCAFEF00D, 1'b0, ed, ee, "pre_write");
        @(negedge clk);
        bus.req = 1'b1;
        bus.mem_addr = 32'h20;
        bus.mem_write_en = 1'b1;
        set_lanes(32'h11223344);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(negedge clk);
        check("abort busy", {31'h0, bus.busy}, 32'h0);
        check("abort ready", {31'h0, bus.mem_ready}, 32'h0);
        check("abort lanes", out_word(), 32'h0);
        model_out = 32'h0;
        model_access(32'h20, 1'b0, 32'h0, ed, ee);
        do_access(32'h20, 1'b0, 32'h0, 1'b0, ed, ee, "abort_read");
        check("abort value", ed, 32'hCAFEF00D);

        // Halted core: requests refused
        @(negedge clk);
        bus.halted = 1'b1;
        bus.req = 1'b1;
        bus.mem_addr = 32'h10;
        bus.mem_write_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("halted c%0d", k), {30'h0, bus.busy, bus.mem_ready}, 32'h0);
        end
        bus.req = 1'b0;
        bus.halted = 1'b0;
        model_access(32'h10, 1'b0, 32'h0, ed, ee);
        do_access(32'h10, 1'b0, 32'h0, 1'b0, ed, ee, "after_halt");

        // Randomized accesses against the reference model
        for (int n = 0; n < 60; n++) begin
            idx  = int'($urandom_range(0, WORDS - 1));
            sel  = int'($urandom_range(0, 9));
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            addr = 32'(idx) << 2;
            if (sel == 0) addr = addr | 32'($urandom_range(1, 3));
            else if (sel == 1) addr = addr | (32'h1 << $urandom_range(ADDR_WIDTH, 31));
            else if (!we && !known[idx]) we = 1'b1;
            model_access(addr, we, wd, ed, ee);
            do_access(addr, we, wd, 1'($urandom_range(0, 3) == 0), ed, ee, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
